// File: rtl/dec2to4_pol_core.sv
// rtl/dec2to4_pol_core.sv - 2-to-4 decoder with selectable polarity, registered copy and change counter
module dec2to4_pol_core #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             A2,
    input  logic             A1,
    input  logic             A0,
    output logic [3:0]       D,
    output logic [3:0]       D_q,
    output logic             pol_q,
    output logic             chg_pulse,
    output logic [CNT_W-1:0] chg_cnt
);

    logic [3:0]       onehot;
    logic [3:0]       dec_q;
    logic             pol_reg_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             changed;

    // Codes 00 and 01 map to D1 and D0 respectively; the swap is intentional.
    always_comb begin
        onehot = 4'b0000;
        unique case ({A1, A0})
            2'b00: onehot = 4'b0010;
            2'b01: onehot = 4'b0001;
            2'b10: onehot = 4'b0100;
            2'b11: onehot = 4'b1000;
            default: onehot = 4'b0000;
        endcase
    end

    assign D       = A2 ? onehot : ~onehot;
    assign changed = (D != dec_q);

    always_comb begin
        cnt_d = cnt_q;
        if (changed && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dec_q     <= 4'b0000;
            pol_reg_q <= 1'b0;
            pulse_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            dec_q     <= D;
            pol_reg_q <= A2;
            pulse_q   <= changed;
            cnt_q     <= cnt_d;
        end
    end

    assign D_q       = dec_q;
    assign pol_q     = pol_reg_q;
    assign chg_pulse = pulse_q;
    assign chg_cnt   = cnt_q;

endmodule

// File: tb/tb_dec2to4_pol_core.sv
// tb/tb_dec2to4_pol_core.sv - scoreboard bench for dec2to4_pol_core (default and 2-bit counter)
module tb_dec2to4_pol_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       A2 = 1'b0, A1 = 1'b0, A0 = 1'b0;
    logic [3:0] D, D_q, D2, D_q2;
    logic       pol_q, chg_pulse, pol_q2, chg_pulse2;
    logic [7:0] chg_cnt;
    logic [1:0] chg_cnt2;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [3:0] dq;
        logic       pol;
        logic       pulse;
        logic [7:0] cnt;
        logic [1:0] cnt2;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] m_dq   = 4'b0000;
    logic [7:0] m_cnt  = 8'd0;
    logic [1:0] m_cnt2 = 2'd0;

    dec2to4_pol_core #(.CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .A2(A2), .A1(A1), .A0(A0),
        .D(D), .D_q(D_q), .pol_q(pol_q), .chg_pulse(chg_pulse), .chg_cnt(chg_cnt)
    );

    dec2to4_pol_core #(.CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .A2(A2), .A1(A1), .A0(A0),
        .D(D2), .D_q(D_q2), .pol_q(pol_q2), .chg_pulse(chg_pulse2), .chg_cnt(chg_cnt2)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [3:0] ref_dec(input logic a2, input logic a1, input logic a0);
        logic [3:0] v;
        case ({a1, a0})
            2'b00:   v = 4'b0010;
            2'b01:   v = 4'b0001;
            2'b10:   v = 4'b0100;
            default: v = 4'b1000;
        endcase
        return a2 ? v : ~v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_dq   = 4'b0000;
        m_cnt  = 8'd0;
        m_cnt2 = 2'd0;
    endtask

    task automatic check_reset_regs();
        check("rst_dq",     32'(D_q),        32'h0);
        check("rst_pol",    32'(pol_q),      32'h0);
        check("rst_pulse",  32'(chg_pulse),  32'h0);
        check("rst_cnt",    32'(chg_cnt),    32'h0);
        check("rst_cnt2",   32'(chg_cnt2),   32'h0);
        check("rst_pulse2", 32'(chg_pulse2), 32'h0);
    endtask

    task automatic set_and_check_d(input string tag, input logic a2, input logic a1, input logic a0,
                                   input logic [3:0] want);
        A2 = a2; A1 = a1; A0 = a0;
        #1;
        check(tag, 32'(D), 32'(want));
    endtask

    // Drive inputs mid-cycle, queue the post-edge expectation, then compare after the edge.
    task automatic step(input logic a2, input logic a1, input logic a0);
        exp_t       e;
        exp_t       got;
        logic [3:0] dv;
        A2 = a2; A1 = a1; A0 = a0;
        #1;
        dv = ref_dec(a2, a1, a0);
        check("d_comb", 32'(D), 32'(dv));
        check("d_ones", 32'($countones(D)), a2 ? 32'd1 : 32'd3);
        e.pulse = (dv != m_dq);
        if (e.pulse) begin
            if (m_cnt != 8'hFF) m_cnt = m_cnt + 8'd1;
            if (m_cnt2 != 2'd3) m_cnt2 = m_cnt2 + 2'd1;
        end
        m_dq   = dv;
        e.dq   = dv;
        e.pol  = a2;
        e.cnt  = m_cnt;
        e.cnt2 = m_cnt2;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        check("dq",     32'(D_q),        32'(got.dq));
        check("pol",    32'(pol_q),      32'(got.pol));
        check("pulse",  32'(chg_pulse),  32'(got.pulse));
        check("cnt",    32'(chg_cnt),    32'(got.cnt));
        check("dq2",    32'(D_q2),       32'(got.dq));
        check("pulse2", 32'(chg_pulse2), 32'(got.pulse));
        check("cnt2",   32'(chg_cnt2),   32'(got.cnt2));
        @(negedge clk);
    endtask

    initial begin
        logic [1:0] sat_tbl [6];
        logic [3:0] hi_tbl [4];
        logic [3:0] lo_tbl [4];
        hi_tbl = '{4'b0010, 4'b0001, 4'b0100, 4'b1000};
        lo_tbl = '{4'b1101, 4'b1110, 4'b1011, 4'b0111};
        sat_tbl = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

        #1;
        check_reset_regs();

        // Decoder is live while reset holds the registers.
        for (int i = 0; i < 4; i++) begin
            set_and_check_d("sweep_hi", 1'b1, i[1], i[0], hi_tbl[i]);
        end
        for (int i = 0; i < 4; i++) begin
            set_and_check_d("sweep_lo", 1'b0, i[1], i[0], lo_tbl[i]);
        end
        check_reset_regs();

        @(negedge clk);
        A2 = 1'b0; A1 = 1'b1; A0 = 1'b0;
        rst = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("flip_dq", 32'(D_q), 32'h4);

        // A1/A0 glitch that returns before the edge must not count.
        A1 = 1'b0; A0 = 1'b1;
        #1;
        A1 = 1'b1; A0 = 1'b0;
        step(1'b1, 1'b1, 1'b0);

        while (m_cnt < 8'd5) begin
            step(1'b1, ~m_dq[2], 1'b0);
        end
        check("pre_rst_cnt", 32'(chg_cnt), 32'd5);

        rst = 1'b1;
        #1;
        model_reset();
        check_reset_regs();
        set_and_check_d("rst_track0", 1'b0, 1'b0, 1'b1, 4'b1110);
        set_and_check_d("rst_track1", 1'b1, 1'b1, 1'b1, 4'b1000);
        check_reset_regs();
        @(negedge clk);
        rst = 1'b0;
        step(1'b1, 1'b1, 1'b1);
        check("post_rst_cnt1", 32'(chg_cnt), 32'd1);
        step(1'b1, 1'b1, 1'b1);
        check("post_rst_pulse0", 32'(chg_pulse), 32'd0);

        rst = 1'b1;
        #1;
        model_reset();
        check_reset_regs();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, i[0] ? 1'b1 : 1'b0, i[0] ? 1'b1 : 1'b0);
            check("sat_tbl", 32'(chg_cnt2), 32'(sat_tbl[i]));
            check("sat_pulse", 32'(chg_pulse2), 32'd1);
        end

        for (int i = 0; i < 60; i++) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        rst = 1'b1;
        #1;
        check("d_after_run", 32'(D), 32'(ref_dec(A2, A1, A0)));
        check_reset_regs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
